// File: rtl/paddle_motion.sv
// paddle_motion: tick-paced paddle position with edge clamping and a hold-to-accelerate speed profile.
// Define PADDLE_AUTO_EN to add the ball_y port and the ball-tracking auto mode (up_down[2]).
module paddle_motion #(
    parameter int Y_WIDTH       = 10,
    parameter int SCREEN_H      = 480,
    parameter int PADDLE_H      = 40,
    parameter int RESET_Y       = 220,
    parameter int MAX_SPEED     = 4,
    parameter int ACCEL_TICKS   = 8,
    parameter int AUTO_DEADZONE = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [2:0]                     up_down,
    output logic [Y_WIDTH-1:0]             y,
    output logic [$clog2(MAX_SPEED+1)-1:0] speed,
    output logic                           moving,
    output logic                           at_top,
    output logic                           at_bottom
`ifdef PADDLE_AUTO_EN
    ,
    input  logic [Y_WIDTH-1:0]             ball_y
`endif
);
    localparam int Y_MAX  = SCREEN_H - PADDLE_H;
    localparam int SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
    localparam int EXT_W  = Y_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_e;

    if (PADDLE_H >= SCREEN_H) begin : g_chk_paddle
        $fatal(1, "paddle_motion: PADDLE_H must be smaller than SCREEN_H");
    end
    if (SCREEN_H > 2**Y_WIDTH) begin : g_chk_width
        $fatal(1, "paddle_motion: SCREEN_H does not fit in Y_WIDTH bits");
    end
    if (RESET_Y > Y_MAX || RESET_Y < 0) begin : g_chk_reset_y
        $fatal(1, "paddle_motion: RESET_Y must lie in 0..SCREEN_H-PADDLE_H");
    end
    if (MAX_SPEED < 1) begin : g_chk_speed
        $fatal(1, "paddle_motion: MAX_SPEED must be at least 1");
    end
    if (ACCEL_TICKS < 1) begin : g_chk_accel
        $fatal(1, "paddle_motion: ACCEL_TICKS must be at least 1");
    end

    state_e                  state_q, state_d;
    dir_e                    dir_q, dir_d;
    dir_e                    dir;
    logic [SPD_W-1:0]        speed_q, speed_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic signed [EXT_W-1:0] y_ext, step_s, y_next;

`ifdef PADDLE_AUTO_EN
    localparam int AW = EXT_W + 1;
    logic signed [AW-1:0] centre_s, ball_s;

    assign centre_s = AW'(y_q) + AW'(PADDLE_H / 2);
    assign ball_s   = AW'(ball_y);

    // Auto mode steers the paddle centre toward the ball, ignoring the manual bits.
    always_comb begin
        dir = DIR_NONE;
        if (up_down[2]) begin
            if (ball_s < centre_s - AW'(AUTO_DEADZONE)) begin
                dir = DIR_DEC;
            end else if (ball_s > centre_s + AW'(AUTO_DEADZONE)) begin
                dir = DIR_INC;
            end
        end else begin
            case (up_down[1:0])
                2'b01:   dir = DIR_INC;
                2'b10:   dir = DIR_DEC;
                default: dir = DIR_NONE;
            endcase
        end
    end
`else
    logic unused_auto;
    assign unused_auto = up_down[2] ^ (AUTO_DEADZONE != 0);

    always_comb begin
        case (up_down[1:0])
            2'b01:   dir = DIR_INC;
            2'b10:   dir = DIR_DEC;
            default: dir = DIR_NONE;
        endcase
    end
`endif

    assign y_ext = $signed({2'b00, y_q});

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        y_d     = y_q;
        step_s  = '0;
        y_next  = y_ext;
        if (tick) begin
            if (dir == DIR_NONE) begin
                state_d = IDLE;
                speed_d = '0;
                hold_d  = '0;
            end else begin
                if (state_q == IDLE || dir != dir_q) begin
                    speed_d = SPD_W'(1);
                    hold_d  = HOLD_W'(1);
                    state_d = (MAX_SPEED == 1) ? CRUISE : ACCEL;
                end else if (state_q == ACCEL) begin
                    if (hold_q == HOLD_W'(ACCEL_TICKS)) begin
                        speed_d = speed_q + 1'b1;
                        hold_d  = HOLD_W'(1);
                        if (speed_d == SPD_W'(MAX_SPEED)) begin
                            state_d = CRUISE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                dir_d  = dir;
                step_s = $signed(EXT_W'(speed_d));
                y_next = (dir == DIR_INC) ? (y_ext + step_s) : (y_ext - step_s);
                // Hitting either edge stops the paddle so a fresh press restarts at speed 1.
                if (y_next < 0 || y_next > EXT_W'(Y_MAX)) begin
                    y_d     = (y_next < 0) ? '0 : Y_WIDTH'(Y_MAX);
                    state_d = IDLE;
                    speed_d = '0;
                    hold_d  = '0;
                end else begin
                    y_d = y_next[Y_WIDTH-1:0];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            speed_q <= '0;
            hold_q  <= '0;
            y_q     <= Y_WIDTH'(RESET_Y);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign speed     = speed_q;
    assign moving    = (speed_q != '0);
    assign at_top    = (y_q == '0);
    assign at_bottom = (y_q == Y_WIDTH'(Y_MAX));
endmodule

// File: tb/tb_paddle_motion.sv
// tb_paddle_motion: directed and randomized stimulus scored against a run-length speed model.
// Auto-mode checks are compiled in only when PADDLE_AUTO_EN is defined.
module tb_paddle_motion;
    localparam int Y_WIDTH       = 10;
    localparam int SCREEN_H      = 480;
    localparam int PADDLE_H      = 40;
    localparam int RESET_Y       = 220;
    localparam int MAX_SPEED     = 4;
    localparam int ACCEL_TICKS   = 8;
    localparam int AUTO_DEADZONE = 4;
    localparam int Y_MAX         = SCREEN_H - PADDLE_H;
    localparam int SPD_W         = $clog2(MAX_SPEED + 1);

    logic               clock = 1'b0;
    logic               reset;
    logic               tick;
    logic [2:0]         up_down;
    logic [Y_WIDTH-1:0] ball_y;
    logic [Y_WIDTH-1:0] y;
    logic [SPD_W-1:0]   speed;
    logic               moving;
    logic               at_top;
    logic               at_bottom;

    paddle_motion #(
        .Y_WIDTH      (Y_WIDTH),
        .SCREEN_H     (SCREEN_H),
        .PADDLE_H     (PADDLE_H),
        .RESET_Y      (RESET_Y),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_TICKS  (ACCEL_TICKS),
        .AUTO_DEADZONE(AUTO_DEADZONE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .up_down  (up_down),
        .y        (y),
        .speed    (speed),
        .moving   (moving),
        .at_top   (at_top),
        .at_bottom(at_bottom)
`ifdef PADDLE_AUTO_EN
        ,
        .ball_y   (ball_y)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int y;
        int speed;
        int phase;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   phase = 0;

    // Reference model: speed follows from how many same-direction ticks in a row have occurred.
    int m_y, m_speed, m_run, m_dir;

    function automatic int decode_dir(input logic [2:0] ud, input int by, input int cur_y);
        int c;
`ifdef PADDLE_AUTO_EN
        if (ud[2]) begin
            c = cur_y + PADDLE_H / 2;
            if (by < c - AUTO_DEADZONE) return -1;
            if (by > c + AUTO_DEADZONE) return 1;
            return 0;
        end
`endif
        c = cur_y + by;
        if (ud[1:0] == 2'b01) return 1;
        if (ud[1:0] == 2'b10) return -1;
        return 0;
    endfunction

    task automatic model_step(input logic rst, input logic tk, input logic [2:0] ud, input int by);
        int d, nxt;
        if (rst) begin
            m_y = RESET_Y; m_speed = 0; m_run = 0; m_dir = 0;
        end else if (tk) begin
            d = decode_dir(ud, by, m_y);
            if (d == 0) begin
                m_run = 0; m_speed = 0;
            end else begin
                m_run   = (m_run > 0 && d == m_dir) ? m_run + 1 : 1;
                m_dir   = d;
                m_speed = 1 + (m_run - 1) / ACCEL_TICKS;
                if (m_speed > MAX_SPEED) m_speed = MAX_SPEED;
                nxt = m_y + d * m_speed;
                if (nxt < 0 || nxt > Y_MAX) begin
                    m_y = (nxt < 0) ? 0 : Y_MAX;
                    m_run = 0; m_speed = 0;
                end else begin
                    m_y = nxt;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic tk, input logic [2:0] ud, input int by);
        exp_t e;
        reset   = rst;
        tick    = tk;
        up_down = ud;
        ball_y  = by[Y_WIDTH-1:0];
        @(posedge clock);
        model_step(rst, tk, ud, by);
        e.y = m_y; e.speed = m_speed; e.phase = phase;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so each scored cycle is compared at the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (y !== e.y || speed !== e.speed || moving !== (e.speed != 0) ||
                    at_top !== (e.y == 0) || at_bottom !== (e.y == Y_MAX)) begin
                    bad++;
                    $display("FAIL sb_phase%0d: got y=%0d speed=%0d moving=%0b top=%0b bottom=%0b, expected y=%0d speed=%0d",
                             e.phase, y, speed, moving, at_top, at_bottom, e.y, e.speed);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ud;
        reset = 1'b1; tick = 1'b0; up_down = 3'b000; ball_y = '0;

        phase = 1;
        cyc(1, 0, 3'b000, 0);
        cyc(1, 1, 3'b001, 0);
        check("reset_y", y, 220);
        check("reset_speed", speed, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 3'b001, 0);
        check("notick_y", y, 220);

        phase = 2;
        for (int t = 1; t <= 25; t++) begin
            cyc(0, 0, 3'b001, 0);
            cyc(0, 0, 3'b001, 0);
            cyc(0, 0, 3'b001, 0);
            cyc(0, 1, 3'b001, 0);
            if (t == 8)  begin check("t8_y", y, 228);  check("t8_speed", speed, 1); end
            if (t == 9)  begin check("t9_y", y, 230);  check("t9_speed", speed, 2); end
            if (t == 16) check("t16_y", y, 244);
            if (t == 24) begin check("t24_y", y, 268); check("t24_speed", speed, 3); end
            if (t == 25) begin check("t25_y", y, 272); check("t25_speed", speed, 4); end
        end

        phase = 3;
        cyc(0, 1, 3'b010, 0);
        check("reverse_y", y, 271);
        check("reverse_speed", speed, 1);
        cyc(0, 1, 3'b011, 0);
        check("both_y", y, 271);
        check("both_speed", speed, 0);

        phase = 4;
        for (int i = 0; i < 200; i++) cyc(0, 1, 3'b001, 0);
        check("bottom_y", y, Y_MAX);
        check("bottom_flag", at_bottom, 1);
        check("bottom_speed", speed, 0);
        for (int i = 0; i < 200; i++) cyc(0, 1, 3'b010, 0);
        check("top_y", y, 0);
        check("top_flag", at_top, 1);

        phase = 5;
        for (int i = 0; i < 20; i++) cyc(0, 1, 3'b001, 0);
        check("pre_reset_speed", speed, 3);
        cyc(1, 1, 3'b001, 0);
        check("mid_reset_y", y, 220);
        check("mid_reset_moving", moving, 0);
        cyc(0, 1, 3'b001, 0);
        check("post_reset_y", y, 221);
        check("post_reset_speed", speed, 1);

        phase = 6;
        ud = 3'b001;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) ud = 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 127) == 0), 1'($urandom_range(0, 1)), ud,
                int'($urandom_range(0, SCREEN_H - 1)));
        end

`ifdef PADDLE_AUTO_EN
        phase = 7;
        cyc(1, 0, 3'b000, 0);
        cyc(0, 1, 3'b101, 243);
        check("auto_dead_y", y, 220);
        check("auto_dead_speed", speed, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 3'b101, 100);
        check("auto_down_y", y, 215);
        cyc(1, 0, 3'b000, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 3'b110, 300);
        check("auto_up_y", y, 225);
`endif

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
